high_speed_in_bus_fifo: RTL
===========================

HIGH_SPEED_IN_BUS_FIFO -- requirements
Module: high_speed_in_bus_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of the bundled input word and output word (>=1).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of buffered words (power of two, >=2).
REQ-003 SHALL have parameter SYNC_STAGES, default 2: flip-flop stages on request synchronizer (>=2).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port request  input  1  asynchronous 4-phase request from off-chip/other-domain sender.
REQ-007 SHALL have port in_data  input  DATA_WIDTH  bundled data, stable while request high.
REQ-008 SHALL have port acknowledge  output  1  4-phase acknowledge, registered.
REQ-009 SHALL have port out_data  output  DATA_WIDTH  FIFO head word.
REQ-010 SHALL have port out_valid  output  1  FIFO non-empty; out_data meaningful.
REQ-011 SHALL have port out_ready  input  1  consumer accepts head word when out_valid&out_ready.
REQ-012 SHALL have port fill_level  output  $clog2(FIFO_DEPTH)+1  stored word count, 0..FIFO_DEPTH.

Function
REQ-013 SHALL pass request through SYNC_STAGES flops (request_sync); no other logic on raw request.
REQ-014 SHALL implement handshake FSM with states IDLE and ACK.
REQ-015 In IDLE, capture condition = request_sync & ~full; on capture SHALL write in_data into FIFO that edge, set acknowledge=1, go ACK.
REQ-016 In IDLE with request_sync & full SHALL hold acknowledge=0, write nothing, stay IDLE (back-pressure, no word dropped).
REQ-017 In ACK SHALL hold acknowledge=1 until request_sync=0, then set acknowledge=0 and go IDLE the same edge.
REQ-018 SHALL capture exactly one word per request rising edge; request_sync staying high in ACK SHALL NOT write again.
REQ-019 Latency: request rise to acknowledge rise = SYNC_STAGES+1 cycles when not full; request fall to acknowledge fall = SYNC_STAGES+1 cycles.
REQ-020 Written word SHALL appear on out_data with out_valid=1 the cycle after the write when FIFO was empty (1-cycle latency, show-ahead).
REQ-021 Read occurs when out_valid&out_ready; out_ready while empty SHALL have no effect.
REQ-022 full SHALL be evaluated on current fill_level, so a read in the same cycle does not unblock a write on a full FIFO; capture follows next cycle.
REQ-023 Simultaneous write and read when not full and not empty SHALL leave fill_level unchanged.
REQ-024 Read/write pointers SHALL be $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; order strictly FIFO.
REQ-025 fill_level SHALL never exceed FIFO_DEPTH nor go below 0.

Reset
REQ-026 On rst_n=0 SHALL asynchronously clear synchronizer flops, FSM to IDLE, acknowledge=0, pointers=0, fill_level=0, out_valid=0.
REQ-027 Reset mid-handshake SHALL discard buffered words; after release, a still-high request SHALL be treated as a new request (one capture).
REQ-028 FIFO storage array need not be reset; out_data undefined while out_valid=0.

Structure
REQ-029 FSM state encoding (IDLE, ACK) SHALL live in shared package aer_pkg.
REQ-030 FIFO storage, pointers and fill_level SHALL be one sub-module sync_fifo (params DATA_WIDTH, FIFO_DEPTH); synchronizer a parametrised flop chain inside the top.

Verification
REQ-031 Reset then one request with in_data=0xA5 -> acknowledge rises 3 cycles after request (SYNC_STAGES=2), out_valid=1, out_data=0xA5, fill_level=1.
REQ-032 Four back-to-back 4-phase transfers 0x01..0x04, out_ready=0 -> fill_level=4, fifth request held with acknowledge=0; one read -> fifth captured, order 0x01..0x05 preserved.
REQ-033 Continuous streaming 16 words with out_ready=1 -> all 16 delivered in order, pointers wrap, fill_level never >1.
REQ-034 request held high 20 cycles -> exactly one word written, acknowledge high until 3 cycles after request falls.
REQ-035 rst_n asserted with fill_level=3 and acknowledge=1, request still high -> outputs clear immediately; after release exactly one new capture.
REQ-036 out_ready=1 with empty FIFO for 10 cycles -> fill_level stays 0, no spurious out_valid.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared types for the asynchronous-request input handshake blocks.
package aer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hs_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head word is visible on rd_data whenever not empty.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign full    = (fill_level == CNT_W'(FIFO_DEPTH));
  assign empty   = (fill_level == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage is deliberately left unreset; out_valid gates its meaning.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   fill_level <= fill_level + CNT_W'(1);
        2'b01:   fill_level <= fill_level - CNT_W'(1);
        default: fill_level <= fill_level;
      endcase
    end
  end

endmodule

// File: rtl/high_speed_in_bus_fifo.sv
// Receives words over an asynchronous 4-phase request/acknowledge link and
// buffers them in a show-ahead FIFO for a synchronous consumer.
module high_speed_in_bus_fifo
  import aer_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          request,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          acknowledge,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   request_sync;
  hs_state_t              state;
  logic                   full;
  logic                   empty;
  logic                   wr_en;

  // Raw request is asynchronous; only the last synchronizer stage is trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], request};
    end
  end

  assign request_sync = sync_q[SYNC_STAGES-1];
  assign wr_en        = (state == IDLE) & request_sync & ~full;
  assign out_valid    = ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acknowledge <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (request_sync && !full) begin
            state       <= ACK;
            acknowledge <= 1'b1;
          end
        end
        ACK: begin
          if (!request_sync) begin
            state       <= IDLE;
            acknowledge <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          acknowledge <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (in_data),
    .rd_en      (out_ready),
    .rd_data    (out_data),
    .full       (full),
    .empty      (empty),
    .fill_level (fill_level)
  );

endmodule
